// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants for the pipelined carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int   CLA_SLICE_W = 4;
    localparam logic MODE_ADD    = 1'b0;
    localparam logic MODE_SUB    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cla_slice_stage.sv
`default_nettype none
// ============================================================================
// Module      : cla_slice_stage
// Description : One 4-bit CLA slice plus its pipeline stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_slice_stage
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   valid_in,
    input  logic [CLA_SLICE_W-1:0] a,
    input  logic [CLA_SLICE_W-1:0] b,
    input  logic                   cin,
    input  logic [WIDTH-1:0]       sum_in,
    output logic                   valid_q,
    output logic [WIDTH-1:0]       sum_q,
    output logic                   cout_q,
    output logic                   c3_q
);

    localparam int               c_offset  = IDX * CLA_SLICE_W;
    localparam logic [WIDTH-1:0] c_lo_mask = {WIDTH{1'b1}} >> (WIDTH - c_offset);

    logic [CLA_SLICE_W-1:0] w_g;
    logic [CLA_SLICE_W-1:0] w_p;
    logic [CLA_SLICE_W:0]   w_c;
    logic [CLA_SLICE_W-1:0] w_s;
    logic [WIDTH-1:0]       w_s_placed;

    always_comb begin
        w_g    = a & b;
        w_p    = a ^ b;
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
        w_s        = w_p ^ w_c[CLA_SLICE_W-1:0];
        w_s_placed = {{(WIDTH-CLA_SLICE_W){1'b0}}, w_s} << c_offset;
    end

    // Resolved lower bits ride along; bits above this slice stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            c3_q    <= 1'b0;
        end else if (en) begin
            valid_q <= valid_in;
            sum_q   <= (sum_in & c_lo_mask) | w_s_placed;
            cout_q  <= w_c[4];
            c3_q    <= w_c[3];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Pipelined carry-lookahead add/subtract, one 4-bit slice per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSLICE = WIDTH / CLA_SLICE_W;

    logic             w_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;

    logic [NSLICE-1:0] w_valid;
    logic [NSLICE-1:0] w_cout;
    logic [NSLICE-1:0] w_c3;
    logic [WIDTH-1:0]  w_sum_q [NSLICE];
    logic              w_c3_unused;

    // Operand skew: entry k holds the operands shifted so slice k sits at [3:0].
    logic [WIDTH-1:0] r_a_skew [1:NSLICE-1];
    logic [WIDTH-1:0] r_b_skew [1:NSLICE-1];

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_accept = in_valid && w_adv;
    assign w_b_eff  = (in_sub == MODE_SUB) ? ~in_b : in_b;
    assign w_cin0   = (in_sub == MODE_ADD) ? in_cin : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < NSLICE; k++) begin
                r_a_skew[k] <= '0;
                r_b_skew[k] <= '0;
            end
        end else if (w_adv) begin
            r_a_skew[1] <= in_a >> CLA_SLICE_W;
            r_b_skew[1] <= w_b_eff >> CLA_SLICE_W;
            for (int k = 2; k < NSLICE; k++) begin
                r_a_skew[k] <= r_a_skew[k-1] >> CLA_SLICE_W;
                r_b_skew[k] <= r_b_skew[k-1] >> CLA_SLICE_W;
            end
        end
    end

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        logic [CLA_SLICE_W-1:0] w_a_sl;
        logic [CLA_SLICE_W-1:0] w_b_sl;
        logic                   w_cin_sl;
        logic                   w_vin;
        logic [WIDTH-1:0]       w_sum_in;

        if (k == 0) begin : g_head
            assign w_a_sl   = in_a[CLA_SLICE_W-1:0];
            assign w_b_sl   = w_b_eff[CLA_SLICE_W-1:0];
            assign w_cin_sl = w_cin0;
            assign w_vin    = w_accept;
            assign w_sum_in = '0;
        end else begin : g_body
            assign w_a_sl   = r_a_skew[k][CLA_SLICE_W-1:0];
            assign w_b_sl   = r_b_skew[k][CLA_SLICE_W-1:0];
            assign w_cin_sl = w_cout[k-1];
            assign w_vin    = w_valid[k-1];
            assign w_sum_in = w_sum_q[k-1];
        end

        cla_slice_stage #(
            .WIDTH (WIDTH),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (w_adv),
            .valid_in (w_vin),
            .a        (w_a_sl),
            .b        (w_b_sl),
            .cin      (w_cin_sl),
            .sum_in   (w_sum_in),
            .valid_q  (w_valid[k]),
            .sum_q    (w_sum_q[k]),
            .cout_q   (w_cout[k]),
            .c3_q     (w_c3[k])
        );
    end

    // Only the MSB slice's c3 has a consumer.
    assign w_c3_unused = ^w_c3[NSLICE-2:0];

    assign out_valid = w_valid[NSLICE-1];
    assign out_sum   = w_sum_q[NSLICE-1];
    assign out_cout  = w_cout[NSLICE-1];
    assign out_ovf   = w_c3[NSLICE-1] ^ w_cout[NSLICE-1];

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Directed vector table plus stall and reset sequences, WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    localparam int WIDTH = 16;
    localparam int NVEC  = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    // Called just after a rising edge; one beat in, waits for its result.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        out_ready = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_sub    = v.sub;
        in_valid  = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, 32'd4);
        check($sformatf("v%0d_sum", idx), {16'd0, out_sum}, {16'd0, v.sum});
        check($sformatf("v%0d_cout", idx), {31'd0, out_cout}, {31'd0, v.cout});
        check($sformatf("v%0d_ovf", idx), {31'd0, out_ovf}, {31'd0, v.ovf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] q [$];
        logic [17:0] exp_r;
        bit          rdy_pat [6];
        int          sent, got, cyc, extra;
        bit          held;
        logic [15:0] h_sum;
        logic        h_cout, h_ovf;
        logic [15:0] ba, bb;
        logic        bcin, bsub;

        //          a        b        cin   sub   sum      cout  ovf
        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'hCF13, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_cout", {31'd0, out_cout}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);
        @(posedge clk); #1;

        // 10 back-to-back beats against a stalling consumer
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
        while (got < 10 && cyc < 200) begin
            ba   = 16'(sent * 16'h1357 + 16'h0F0F);
            bb   = 16'(sent * 16'h2468 + 16'h00F1);
            bsub = sent[0];
            bcin = sent[1];
            in_valid  = (sent < 10);
            in_a      = ba;
            in_b      = bb;
            in_sub    = bsub;
            in_cin    = bcin;
            out_ready = rdy_pat[cyc % 6];
            @(negedge clk);
            check($sformatf("bb_in_ready_c%0d", cyc), {31'd0, in_ready},
                  {31'd0, !(out_valid && !out_ready)});
            if (held) begin
                check($sformatf("bb_hold_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
                check($sformatf("bb_hold_data_c%0d", cyc), {14'd0, out_ovf, out_cout, out_sum},
                      {14'd0, h_ovf, h_cout, h_sum});
            end
            held   = out_valid && !out_ready;
            h_sum  = out_sum;
            h_cout = out_cout;
            h_ovf  = out_ovf;
            if (out_valid && out_ready) begin
                exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                check($sformatf("bb_result_%0d", got), {14'd0, out_ovf, out_cout, out_sum},
                      {14'd0, exp_r});
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(ba, bb, bcin, bsub));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bb_all_received", got, 32'd10);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("bb_no_duplicates", extra, 32'd0);

        // Fill the pipe, then reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 16'(16'h1111 * (i + 1));
            in_b     = 16'h0101;
            in_cin   = 1'b0;
            in_sub   = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("fill_out_valid", {31'd0, out_valid}, 32'd1);
        check("fill_out_sum", {16'd0, out_sum}, 32'h1212);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_sum", {16'd0, out_sum}, 32'd0);
        check("midrst_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("postrst_no_stale", extra, 32'd0);
        run_vec(vecs[7], 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
